ls259_loader: RTL and testbench
===============================

LS259_LOADER -- requirements
Module: ls259_loader

Interface
REQ-001 Parameter: AUTO_CLR, default 1, when 1 a CLEAR cycle is issued on the first clock after reset release.
REQ-002 clk  in  1  single system clock; all state changes on posedge clk.
REQ-003 rst_b  in  1  reset, asynchronous and active-low.
REQ-004 wr_valid  in  1  byte-write request from bus decode.
REQ-005 wr_data  in  8  bit values; bit i targets latch output Q[i].
REQ-006 wr_mask  in  8  bit i = 1 updates Q[i]; bit i = 0 leaves Q[i] untouched.
REQ-007 wr_ready  out  1  write accepted on a posedge with wr_valid and wr_ready both high.
REQ-008 clr_req  in  1  level request to clear all 8 latch outputs.
REQ-009 S  out  3  latch select, drives ls259 S.
REQ-010 D  out  1  latch data, drives ls259 D.
REQ-011 En_b  out  1  latch enable, active-low, drives ls259 En_b.
REQ-012 clr_b  out  1  latch clear, active-low, drives ls259 clr_b.
REQ-013 shadow  out  8  mirror of ls259 Q, equal to Q after every posedge.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 States SHALL be IDLE, CLEAR and SHIFT; SHIFT SHALL carry a 3-bit index idx.
REQ-016 S, D, En_b, clr_b SHALL be registered outputs with no combinational path from any input.
REQ-017 In IDLE: En_b=1, clr_b=1, S=0, D=0, wr_ready=1 unless clr_req=1.
REQ-018 IDLE with clr_req=1 SHALL go to CLEAR; clr_req has priority over wr_valid, and wr_ready SHALL be 0 in that cycle.
REQ-019 IDLE with wr_valid=1 and clr_req=0 SHALL capture wr_data and wr_mask and go to SHIFT with idx=0.
REQ-020 CLEAR SHALL last exactly 1 cycle with clr_b=0 and En_b=1, then go to IDLE; shadow SHALL become 8'h00 on the ending edge.
REQ-021 In SHIFT: S=idx, D=data[idx], En_b=~mask[idx], clr_b=1; idx SHALL increment each cycle.
REQ-022 Unmasked bits SHALL still consume their cycle, so a write always takes exactly 8 SHIFT cycles.
REQ-023 When En_b=0 on the current cycle, shadow[S] SHALL take the value of D on the next posedge, matching ls259 timing.
REQ-024 wr_ready SHALL also be 1 in SHIFT with idx=7 and clr_req=0; an accept there SHALL go directly to SHIFT idx=0, giving 8-cycle throughput.
REQ-025 At idx=7 with no accept, the block SHALL go to CLEAR if clr_req=1, otherwise to IDLE; clr_req SHALL never abort a SHIFT in progress.
REQ-026 The output pair {clr_b, En_b} = 2'b00 SHALL never be driven.
REQ-027 wr_mask = 8'h00 SHALL still run 8 cycles with En_b=1 throughout, and shadow SHALL be unchanged.
REQ-028 busy SHALL be 1 in CLEAR and SHIFT, and 0 in IDLE.

Reset
REQ-029 While rst_b=0: En_b=1, clr_b=1, S=0, D=0, wr_ready=0, busy=0, shadow=8'h00, idx=0, captured data/mask=0.
REQ-030 Reset assertion in the middle of SHIFT SHALL immediately force En_b=1, abandoning the write.
REQ-031 After rst_b rises with AUTO_CLR=1, the first state SHALL be CLEAR, so shadow=0 reflects real latch contents; with AUTO_CLR=0 the first state SHALL be IDLE.

Verification
REQ-032 After reset and auto-clear, write 8'hA5 with mask 8'hFF -> S=0..7 on consecutive cycles, D=1,0,1,0,0,1,0,1, En_b=0 on all 8 cycles, shadow=8'hA5, ls259 Q=8'hA5.
REQ-033 With shadow at 8'hA5, write 8'h3C with mask 8'h0F -> En_b=0 only for S=0..3, shadow=8'hAC.
REQ-034 wr_valid held high with two queued writes (8'hFF then 8'h00, both mask 8'hFF) -> second write accepted at idx=7 with no IDLE gap, 16 SHIFT cycles total, final shadow=8'h00.
REQ-035 clr_req and wr_valid both asserted in IDLE -> one cycle with clr_b=0 and En_b=1, shadow=0, then the write is accepted; {clr_b, En_b}=2'b00 never observed.
REQ-036 rst_b pulsed low at idx=3 of a 8'hFF write -> En_b=1 within the reset cycle, then a CLEAR cycle, then shadow=8'h00 and wr_ready=1.

Source files
------------

// File: rtl/ls259_loader_if.sv
// Write/clear request bus between bus decode and the ls259 loader.
`timescale 1ns/1ps
interface ls259_loader_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic [7:0] wr_mask;
    logic       wr_ready;
    logic       clr_req;

    modport master (output wr_valid, output wr_data, output wr_mask, output clr_req,
                    input  wr_ready);
    modport slave  (input  wr_valid, input  wr_data, input  wr_mask, input  clr_req,
                    output wr_ready);
endinterface

// File: rtl/ls259_loader.sv
// Serialises masked byte writes onto an ls259 addressable latch, one bit per
// cycle, and keeps a shadow copy of the latch outputs.
`timescale 1ns/1ps
module ls259_loader #(
    parameter bit AUTO_CLR = 1'b1
) (
    input  logic         clk,
    input  logic         rst_b,
    ls259_loader_if.slave bus,
    output logic [2:0]   S,
    output logic         D,
    output logic         En_b,
    output logic         clr_b,
    output logic [7:0]   shadow,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT} state_t;

    state_t     state, state_nx;
    logic [2:0] idx, idx_nx;
    logic [7:0] data_q, data_nx;
    logic [7:0] mask_q, mask_nx;
    logic       run_q;
    logic [2:0] s_nx;
    logic       d_nx, en_nx, clr_nx;

    // Next-state, capture and handshake decode; latch pins are decoded from the
    // next state so they can be registered without any input-to-pin path.
    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        data_nx      = data_q;
        mask_nx      = mask_q;
        bus.wr_ready = 1'b0;
        if (!run_q) begin
            // first clock after reset release
            state_nx = AUTO_CLR ? CLEAR : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    bus.wr_ready = !bus.clr_req;
                    if (bus.clr_req) begin
                        state_nx = CLEAR;
                    end else if (bus.wr_valid) begin
                        state_nx = SHIFT;
                        idx_nx   = 3'd0;
                        data_nx  = bus.wr_data;
                        mask_nx  = bus.wr_mask;
                    end
                end
                CLEAR: state_nx = IDLE;
                SHIFT: begin
                    if (idx == 3'd7) begin
                        bus.wr_ready = !bus.clr_req;
                        idx_nx       = 3'd0;
                        if (bus.wr_valid && !bus.clr_req) begin
                            data_nx = bus.wr_data;
                            mask_nx = bus.wr_mask;
                        end else if (bus.clr_req) begin
                            state_nx = CLEAR;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        idx_nx = idx + 3'd1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end

        s_nx   = 3'd0;
        d_nx   = 1'b0;
        en_nx  = 1'b1;
        clr_nx = 1'b1;
        case (state_nx)
            SHIFT: begin
                s_nx  = idx_nx;
                d_nx  = data_nx[idx_nx];
                en_nx = ~mask_nx[idx_nx];
            end
            CLEAR:   clr_nx = 1'b0;
            default: ;
        endcase
    end

    // State, captured write and registered latch pins.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state  <= IDLE;
            idx    <= 3'd0;
            data_q <= '0;
            mask_q <= '0;
            run_q  <= 1'b0;
            S      <= 3'd0;
            D      <= 1'b0;
            En_b   <= 1'b1;
            clr_b  <= 1'b1;
            busy   <= 1'b0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            data_q <= data_nx;
            mask_q <= mask_nx;
            run_q  <= 1'b1;
            S      <= s_nx;
            D      <= d_nx;
            En_b   <= en_nx;
            clr_b  <= clr_nx;
            busy   <= (state_nx != IDLE);
        end
    end

    // Shadow follows the latch: clear wins, otherwise an enabled bit takes D.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            shadow <= '0;
        end else if (!clr_b) begin
            shadow <= '0;
        end else if (!En_b) begin
            shadow[S] <= D;
        end
    end

endmodule

// File: tb/tb_ls259_loader.sv
// Directed bench for ls259_loader: write patterns, mask handling, back-to-back
// writes, clear priority, clear during shift and reset mid-write.
`timescale 1ns/1ps
module tb_ls259_loader;

    logic       clk;
    logic       rst_b;
    logic [2:0] S;
    logic       D;
    logic       En_b;
    logic       clr_b;
    logic [7:0] shadow;
    logic       busy;
    int         checks;
    int         errors;

    ls259_loader_if bus ();

    ls259_loader #(.AUTO_CLR(1'b1)) dut (
        .clk    (clk),
        .rst_b  (rst_b),
        .bus    (bus.slave),
        .S      (S),
        .D      (D),
        .En_b   (En_b),
        .clr_b  (clr_b),
        .shadow (shadow),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One SHIFT cycle at index i of a write of d under mask m.
    task automatic chk_shift(input logic [7:0] d, input logic [7:0] m, input int i);
        logic [2:0] s_exp;
        s_exp = i[2:0];
        chk("S", S, s_exp);
        chk("D", D, d[i]);
        chk("En_b", En_b, !m[i]);
        chk("clr_b", clr_b, 1);
        chk("busy", busy, 1);
        chk("pair00", {clr_b, En_b} != 2'b00, 1);
        chk("wr_ready", bus.wr_ready, (i == 7) && !bus.clr_req);
    endtask

    // Issue a write from IDLE and check all 8 shift cycles.
    task automatic do_write(input logic [7:0] d, input logic [7:0] m);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        bus.wr_mask  = m;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_shift(d, m, i);
            @(negedge clk);
        end
        chk("busy_end", busy, 0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_b        = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        bus.wr_mask  = 8'h00;
        bus.clr_req  = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_En_b", En_b, 1);
        chk("rst_clr_b", clr_b, 1);
        chk("rst_S", S, 0);
        chk("rst_D", D, 0);
        chk("rst_wr_ready", bus.wr_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_shadow", shadow, 8'h00);

        // auto-clear after release
        rst_b = 1'b1;
        @(negedge clk);
        chk("ac_clr_b", clr_b, 0);
        chk("ac_En_b", En_b, 1);
        chk("ac_busy", busy, 1);
        chk("ac_wr_ready", bus.wr_ready, 0);
        @(negedge clk);
        chk("ac_idle_clr_b", clr_b, 1);
        chk("ac_idle_busy", busy, 0);
        chk("ac_idle_ready", bus.wr_ready, 1);

        // full write, partial mask, empty mask
        do_write(8'hA5, 8'hFF);
        chk("shadow_A5", shadow, 8'hA5);
        do_write(8'h3C, 8'h0F);
        chk("shadow_AC", shadow, 8'hAC);
        do_write(8'hFF, 8'h00);
        chk("shadow_mask0", shadow, 8'hAC);

        // back-to-back writes with wr_valid held high
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hFF;
        bus.wr_mask  = 8'hFF;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            chk_shift(8'hFF, 8'hFF, i);
            if (i == 7) bus.wr_data = 8'h00;
            @(negedge clk);
        end
        chk("b2b_shadow_mid", shadow, 8'hFF);
        bus.wr_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_shift(8'h00, 8'hFF, i);
            @(negedge clk);
        end
        chk("b2b_shadow", shadow, 8'h00);
        chk("b2b_busy", busy, 0);

        // clear request beats a simultaneous write request
        do_write(8'h5A, 8'hFF);
        chk("shadow_5A", shadow, 8'h5A);
        bus.clr_req  = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h81;
        bus.wr_mask  = 8'hFF;
        #1;
        chk("clr_prio_ready", bus.wr_ready, 0);
        @(negedge clk);
        chk("clr_prio_clr_b", clr_b, 0);
        chk("clr_prio_En_b", En_b, 1);
        chk("clr_prio_busy", busy, 1);
        bus.clr_req = 1'b0;
        @(negedge clk);
        chk("clr_prio_shadow", shadow, 8'h00);
        chk("clr_prio_ready2", bus.wr_ready, 1);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_shift(8'h81, 8'hFF, i);
            @(negedge clk);
        end
        chk("shadow_81", shadow, 8'h81);

        // clear request during a shift waits for the write to finish
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h7E;
        bus.wr_mask  = 8'hFF;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) bus.clr_req = 1'b1;
            chk_shift(8'h7E, 8'hFF, i);
            @(negedge clk);
        end
        chk("late_clr_clr_b", clr_b, 0);
        chk("late_clr_En_b", En_b, 1);
        chk("late_clr_shadow_pre", shadow, 8'h7E);
        bus.clr_req = 1'b0;
        @(negedge clk);
        chk("late_clr_shadow", shadow, 8'h00);
        chk("late_clr_busy", busy, 0);

        // reset pulse in the middle of a write
        do_write(8'h00, 8'h00);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hFF;
        bus.wr_mask  = 8'hFF;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_shift(8'hFF, 8'hFF, i);
            if (i < 3) @(negedge clk);
        end
        rst_b = 1'b0;
        #1;
        chk("mid_rst_En_b", En_b, 1);
        chk("mid_rst_ready", bus.wr_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_shadow", shadow, 8'h00);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        chk("mid_rst_clr_b", clr_b, 0);
        chk("mid_rst_clr_En_b", En_b, 1);
        @(negedge clk);
        chk("mid_rst_shadow2", shadow, 8'h00);
        chk("mid_rst_ready2", bus.wr_ready, 1);
        chk("mid_rst_busy2", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
